// File: rtl/meas_imp_pkg.sv
// ---------------------------------------------------------------------------
// meas_imp_pkg : shared widths and root-engine state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package meas_imp_pkg;

  localparam int W_DEF      = 16;
  localparam int ROOT_W_DEF = W_DEF / 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/meas_imp_if.sv
// ---------------------------------------------------------------------------
// meas_imp_if : tick/pulse inputs and measurement results of meas_imp
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface meas_imp_if
  import meas_imp_pkg::*;
#(
  parameter int W = W_DEF
) ();

  logic           ce1us;
  logic           imp;
  logic [W-1:0]   per;
  logic [W/2-1:0] x;
  logic           valid;
  logic           ovf;
  logic           busy;

  modport master (
    output ce1us, imp,
    input  per, x, valid, ovf, busy
  );

  modport slave (
    input  ce1us, imp,
    output per, x, valid, ovf, busy
  );

endinterface

`default_nettype wire

// File: rtl/meas_imp_isqrt.sv
// ---------------------------------------------------------------------------
// isqrt_seq : sequential restoring integer square root, one result bit/clk
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module isqrt_seq
  import meas_imp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   din_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [W/2-1:0] root_o
);

  localparam int RW = W / 2;
  localparam int IW = (RW > 1) ? $clog2(RW) : 1;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  din_q, din_d;
  logic [RW+1:0] rem_q, rem_d;
  logic [RW-1:0] root_q, root_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [RW+1:0] rem_sh;
  logic [RW+1:0] trial;

  // The remainder never exceeds 2*root, so its low RW bits hold it losslessly
  // before shifting in the next two radicand bits.
  assign rem_sh = {rem_q[RW-1:0], din_q[W-1 -: 2]};
  assign trial  = {root_q, 2'b01};

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    rem_d   = rem_q;
    root_d  = root_q;
    iter_d  = iter_q;

    case (state_q)
      ST_CALC: begin
        din_d  = din_q << 2;
        iter_d = iter_q + 1'b1;
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[RW-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[RW-2:0], 1'b0};
        end
        if (iter_q == IW'(RW - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new start wins in any state and throws away the work in progress.
    if (start_i) begin
      state_d = ST_CALC;
      din_d   = din_i;
      rem_d   = '0;
      root_d  = '0;
      iter_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      din_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      iter_q  <= iter_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);
  assign root_o = root_q;

endmodule

`default_nettype wire

// File: rtl/meas_imp.sv
// ---------------------------------------------------------------------------
// meas_imp : measures the imp period in 1 us ticks and recovers sqrt(period)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module meas_imp
  import meas_imp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  meas_imp_if.slave  bus
);

  localparam int         RW      = W / 2;
  localparam logic [W-1:0] CNT_MAX = '1;

  logic          s1_q, s2_q, s3_q;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  per_q, per_d;
  logic [RW-1:0] x_q, x_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          armed_q, armed_d;

  logic          rise;
  logic          start;
  logic          eng_busy;
  logic          eng_done;
  logic [RW-1:0] eng_root;

  assign rise  = s2_q & ~s3_q;
  // The first edge after reset only opens the window; it carries no period.
  assign start = rise & armed_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = '0;
    end else if (bus.ce1us && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    ovf_d   = rise ? 1'b0 : (ovf_q | (cnt_d == CNT_MAX));
    armed_d = armed_q | rise;
    per_d   = start ? cnt_q : per_q;
    valid_d = eng_done & ~start;
    x_d     = valid_d ? eng_root : x_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= '0;
      per_q   <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= bus.imp;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      armed_q <= armed_d;
    end
  end

  isqrt_seq #(
    .W (W)
  ) u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .din_i   (cnt_q),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .root_o  (eng_root)
  );

  assign bus.per   = per_q;
  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = eng_busy;

endmodule

`default_nettype wire

// File: tb/tb_meas_imp.sv
// ---------------------------------------------------------------------------
// tb_meas_imp : directed self-checking bench for meas_imp
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_meas_imp;

  logic clk = 1'b0;
  logic rst;

  meas_imp_if #(.W(16)) bus ();

  meas_imp #(.W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;
  int vx    = 0;
  int vper  = 0;
  int cyc   = 0;
  int per_cyc = 0;
  int val_cyc = 0;
  logic [15:0] per_prev = '0;
  int base;
  int xe [4] = '{1, 1, 1, 2};

  // Record every valid pulse and the cycle of every per change.
  always @(negedge clk) begin
    cyc++;
    if (bus.per !== per_prev) begin
      per_cyc  = cyc;
      per_prev = bus.per;
    end
    if (bus.valid === 1'b1) begin
      vcnt++;
      vx      = int'(bus.x);
      vper    = int'(bus.per);
      val_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_ticks(input int n, input int div);
    for (int t = 0; t < n; t++) begin
      for (int j = 0; j < div; j++) begin
        bus.ce1us = (j == div - 1);
        @(posedge clk);
        #1;
      end
    end
    bus.ce1us = 1'b0;
  endtask

  task automatic pulse();
    bus.imp = 1'b1;
    clks(3);
    bus.imp = 1'b0;
    clks(3);
  endtask

  initial begin
    rst       = 1'b1;
    bus.ce1us = 1'b0;
    bus.imp   = 1'b0;
    clks(3);
    check("rst_per",   32'(bus.per),   0);
    check("rst_x",     32'(bus.x),     0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_ovf",   32'(bus.ovf),   0);
    check("rst_busy",  32'(bus.busy),  0);
    rst = 1'b0;
    clks(2);

    // 100-tick period with a tick every 50 clocks
    pulse();
    check("arm_busy", 32'(bus.busy), 0);
    clks(12);
    check("arm_vcnt", vcnt, 0);
    check("arm_per",  32'(bus.per), 0);
    run_ticks(100, 50);
    pulse();
    clks(10);
    check("p100_per",     32'(bus.per), 100);
    check("p100_x",       vx, 10);
    check("p100_vper",    vper, 100);
    check("p100_vcnt",    vcnt, 1);
    check("p100_latency", val_cyc - per_cyc, 9);
    check("p100_busy",    32'(bus.busy), 0);

    // Short periods 1..4 ticks
    base = vcnt;
    for (int n = 1; n <= 4; n++) begin
      run_ticks(n, 5);
      pulse();
      clks(10);
      check("short_per",  32'(bus.per), n);
      check("short_x",    vx, xe[n-1]);
      check("short_vcnt", vcnt, base + n);
    end

    // Second rise 4 clocks after a measurement start
    run_ticks(50, 1);
    base = vcnt;
    bus.imp = 1'b1;
    clks(2);
    bus.imp   = 1'b0;
    bus.ce1us = 1'b1;
    clks(2);
    bus.imp = 1'b1;
    clks(3);
    bus.ce1us = 1'b0;
    clks(2);
    bus.imp = 1'b0;
    clks(20);
    check("intr_vcnt", vcnt, base + 1);
    check("intr_vper", vper, 3);
    check("intr_x",    vx, 1);
    check("intr_per",  32'(bus.per), 3);

    // Reset in the middle of a root computation
    run_ticks(9, 1);
    pulse();
    check("mid_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    check("mrst_per",   32'(bus.per),   0);
    check("mrst_x",     32'(bus.x),     0);
    check("mrst_valid", 32'(bus.valid), 0);
    check("mrst_ovf",   32'(bus.ovf),   0);
    check("mrst_busy",  32'(bus.busy),  0);
    base = vcnt;
    clks(15);
    check("mrst_novalid", vcnt, base);
    pulse();
    clks(12);
    check("rearm_vcnt", vcnt, base);
    check("rearm_per",  32'(bus.per), 0);
    run_ticks(20, 1);
    pulse();
    clks(10);
    check("after_rst_per",  32'(bus.per), 20);
    check("after_rst_x",    vx, 4);
    check("after_rst_vcnt", vcnt, base + 1);

    // Long high level yields a single rise
    run_ticks(7, 1);
    base    = vcnt;
    bus.imp = 1'b1;
    run_ticks(100, 5);
    check("level_vcnt", vcnt, base + 1);
    check("level_vper", vper, 7);
    check("level_x",    vx, 2);
    bus.imp = 1'b0;
    clks(3);
    run_ticks(10, 1);
    pulse();
    clks(10);
    check("level2_vcnt", vcnt, base + 2);
    check("level2_per",  32'(bus.per), 110);
    check("level2_x",    vx, 10);

    // Counter saturation and overflow
    run_ticks(65534, 1);
    check("ovf_below", 32'(bus.ovf), 0);
    run_ticks(1, 1);
    check("ovf_set", 32'(bus.ovf), 1);
    run_ticks(5, 1);
    check("ovf_hold", 32'(bus.ovf), 1);
    base = vcnt;
    pulse();
    check("ovf_clear", 32'(bus.ovf), 0);
    clks(10);
    check("ovf_per",  32'(bus.per), 65535);
    check("ovf_x",    vx, 255);
    check("ovf_vcnt", vcnt, base + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
